// File: rtl/echo_timer_pkg.sv
// echo_timer_pkg: shared state encoding and width helper for the sonar
// time-of-flight stage (echo_timer and echo_edge_detect).

package echo_timer_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BURST  = 3'd1,
      BLANK  = 3'd2,
      LISTEN = 3'd3,
      REPORT = 3'd4
   } state_t;

   // Bits needed for a counter that must reach max_count-1.
   function automatic int cnt_width(input int max_count);
      return (max_count > 1) ? $clog2(max_count) : 1;
   endfunction

endpackage

// File: rtl/echo_edge_detect.sv
// echo_edge_detect: optional 2-flop synchronizer (ECHO_TIMER_SYNC_EN) followed
// by a previous-sample register; produces a one-cycle pulse on each rising
// edge of the echo comparator level.

module echo_edge_detect (
   input  logic clk_in,
   input  logic rst_in,
   input  logic echo_in,
   output logic rise_out
);

   logic echo_s;
   logic prev_q;

`ifdef ECHO_TIMER_SYNC_EN
   logic [1:0] sync_q;

   // Two-stage synchronizer for the asynchronous comparator level.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], echo_in};
      end
   end

   assign echo_s = sync_q[1];
`else
   assign echo_s = echo_in;
`endif

   // Previous sample tracks the echo level in every state so a level that is
   // already high when listening begins never counts as an edge.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= echo_s;
      end
   end

   assign rise_out = echo_s & ~prev_q;

endmodule

// File: rtl/echo_timer.sv
// echo_timer: per-ping sonar time-of-flight stage. Drives the transducer
// burst, blanks ringdown, times the first echo edge against a timeout and
// hands the result downstream over valid/ready.
// Optional macro ECHO_TIMER_SYNC_EN adds a 2-flop echo synchronizer.

module echo_timer
   import echo_timer_pkg::*;
#(
   parameter int BURST_CYCLES   = 4000,
   parameter int BLANK_CYCLES   = 20000,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int TOF_W          = cnt_width(TIMEOUT_CYCLES)
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start_in,
   input  logic             echo_in,
   output logic             tx_en_out,
   output logic             busy_out,
   output logic [TOF_W-1:0] tof_out,
   output logic             timeout_out,
   output logic             tof_valid_out,
   input  logic             tof_ready_in
);

   localparam logic [TOF_W-1:0] BURST_LAST   = TOF_W'(BURST_CYCLES - 1);
   localparam logic [TOF_W-1:0] BLANK_LAST   = TOF_W'(BURST_CYCLES + BLANK_CYCLES - 1);
   localparam logic [TOF_W-1:0] TIMEOUT_LAST = TOF_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q;
   logic [TOF_W-1:0] count_q;
   logic             echo_rise;

   echo_edge_detect u_edge (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .echo_in  (echo_in),
      .rise_out (echo_rise)
   );

   // Ping sequencer: state, cycle counter and registered output decodes.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q       <= IDLE;
         count_q       <= '0;
         tx_en_out     <= 1'b0;
         busy_out      <= 1'b0;
         tof_out       <= '0;
         timeout_out   <= 1'b0;
         tof_valid_out <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_in) begin
                  state_q   <= BURST;
                  count_q   <= '0;
                  tx_en_out <= 1'b1;
                  busy_out  <= 1'b1;
               end
            end
            BURST: begin
               count_q <= count_q + 1'b1;
               if (count_q == BURST_LAST) begin
                  state_q   <= BLANK;
                  tx_en_out <= 1'b0;
               end
            end
            BLANK: begin
               count_q <= count_q + 1'b1;
               if (count_q == BLANK_LAST) begin
                  state_q <= LISTEN;
               end
            end
            LISTEN: begin
               count_q <= count_q + 1'b1;
               if (echo_rise) begin
                  state_q       <= REPORT;
                  tof_out       <= count_q;
                  timeout_out   <= 1'b0;
                  tof_valid_out <= 1'b1;
               end else if (count_q == TIMEOUT_LAST) begin
                  state_q       <= REPORT;
                  tof_out       <= '0;
                  timeout_out   <= 1'b1;
                  tof_valid_out <= 1'b1;
               end
            end
            REPORT: begin
               if (tof_ready_in) begin
                  state_q       <= IDLE;
                  tof_valid_out <= 1'b0;
                  busy_out      <= 1'b0;
               end
            end
            default: begin
               state_q       <= IDLE;
               tx_en_out     <= 1'b0;
               busy_out      <= 1'b0;
               tof_valid_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_echo_timer.sv
// tb_echo_timer: directed scoreboard bench for echo_timer with
// BURST=4, BLANK=6, TIMEOUT=50. Expected results are queued when a ping
// starts and a separate monitor pops them on each valid/ready handshake.

module tb_echo_timer;

   localparam int BURST   = 4;
   localparam int BLANK   = 6;
   localparam int TIMEOUT = 50;
   localparam int TW      = $clog2(TIMEOUT);
`ifdef ECHO_TIMER_SYNC_EN
   localparam int SYNC_DLY = 2;
`else
   localparam int SYNC_DLY = 0;
`endif

   typedef struct {
      logic [TW-1:0] tof;
      logic          to;
   } result_t;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b0;
   logic          start_in = 1'b0;
   logic          echo_in = 1'b0;
   logic          tof_ready_in = 1'b1;
   logic          tx_en_out;
   logic          busy_out;
   logic [TW-1:0] tof_out;
   logic          timeout_out;
   logic          tof_valid_out;

   result_t sbQ[$];
   int      assertCount = 0;
   int      failCount = 0;
   int      cyc = 0;

   echo_timer #(
      .BURST_CYCLES   (BURST),
      .BLANK_CYCLES   (BLANK),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .start_in      (start_in),
      .echo_in       (echo_in),
      .tx_en_out     (tx_en_out),
      .busy_out      (busy_out),
      .tof_out       (tof_out),
      .timeout_out   (timeout_out),
      .tof_valid_out (tof_valid_out),
      .tof_ready_in  (tof_ready_in)
   );

   // 100 MHz-style clock, period 10.
   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Expected result for an echo level raised while the counter reads n.
   task automatic expectEcho(input int n, output result_t r);
      int d;
      d = n + SYNC_DLY;
      if (d >= BURST + BLANK && d <= TIMEOUT - 1) begin
         r.tof = TW'(d);
         r.to  = 1'b0;
      end else begin
         r.tof = '0;
         r.to  = 1'b1;
      end
   endtask

   // Pulse start for one cycle; on return the DUT counter reads 0.
   task automatic applyStimulus(input bit doPush, input result_t exp);
      if (doPush) sbQ.push_back(exp);
      @(negedge clk_in);
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      cyc = 0;
   endtask

   task automatic gotoCount(input int n);
      while (cyc < n) begin
         @(negedge clk_in);
         cyc++;
      end
   endtask

   task automatic waitValid(input string name);
      int k;
      k = 0;
      while (!tof_valid_out && k < 200) begin
         @(negedge clk_in);
         k++;
      end
      if (!tof_valid_out) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL %s: valid never asserted within 200 cycles", name);
      end
   endtask

   // Monitor: compare each handshaken result with the scoreboard head.
   initial begin
      result_t e;
      forever begin
         @(negedge clk_in);
         #2;
         if (rst_in && tof_valid_out && tof_ready_in) begin
            if (sbQ.size() == 0) begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL sb_unexpected: result tof=%0d to=%0d with empty queue", tof_out, timeout_out);
            end else begin
               e = sbQ.pop_front();
               checkOutput("sb_tof", 32'(tof_out), 32'(e.tof));
               checkOutput("sb_timeout", 32'(timeout_out), 32'(e.to));
            end
         end
      end
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      result_t r;

      // Reset state
      #3;
      checkOutput("rst_tx_en", 32'(tx_en_out), 0);
      checkOutput("rst_busy", 32'(busy_out), 0);
      checkOutput("rst_valid", 32'(tof_valid_out), 0);
      checkOutput("rst_tof", 32'(tof_out), 0);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);

      // Test 1: echo at counter 20
      $display("[TB] test 1: basic echo");
      expectEcho(20, r);
      applyStimulus(1'b1, r);
      checkOutput("t1_tx_en_c0", 32'(tx_en_out), 1);
      checkOutput("t1_busy_c0", 32'(busy_out), 1);
      gotoCount(3);
      checkOutput("t1_tx_en_c3", 32'(tx_en_out), 1);
      gotoCount(4);
      checkOutput("t1_tx_en_c4", 32'(tx_en_out), 0);
      checkOutput("t1_busy_c4", 32'(busy_out), 1);
      gotoCount(20);
      echo_in = 1'b1;
      waitValid("t1_valid");
      @(negedge clk_in);
      echo_in = 1'b0;
      checkOutput("t1_idle_busy", 32'(busy_out), 0);
      checkOutput("t1_idle_valid", 32'(tof_valid_out), 0);

      // Test 2: echoes only during burst/blank -> timeout
      $display("[TB] test 2: blanked echoes then timeout");
      r.tof = '0;
      r.to  = 1'b1;
      applyStimulus(1'b1, r);
      gotoCount(3);  echo_in = 1'b1;
      gotoCount(4);  echo_in = 1'b0;
      gotoCount(7);  echo_in = 1'b1;
      gotoCount(8);  echo_in = 1'b0;
      waitValid("t2_valid");
      @(negedge clk_in);
      checkOutput("t2_idle_busy", 32'(busy_out), 0);

      // Test 3: edge in the final cycle wins over timeout
      $display("[TB] test 3: edge at last cycle");
      expectEcho(TIMEOUT - 1, r);
      applyStimulus(1'b1, r);
      gotoCount(TIMEOUT - 1);
      echo_in = 1'b1;
      waitValid("t3_valid");
      @(negedge clk_in);
      echo_in = 1'b0;

      // Test 4: echo high throughout -> no edge
      $display("[TB] test 4: echo held high");
      r.tof = '0;
      r.to  = 1'b1;
      echo_in = 1'b1;
      applyStimulus(1'b1, r);
      waitValid("t4_valid");
      @(negedge clk_in);
      echo_in = 1'b0;
      @(negedge clk_in);

      // Test 5: back-pressure with start during wait
      $display("[TB] test 5: ready held low");
      tof_ready_in = 1'b0;
      expectEcho(15, r);
      applyStimulus(1'b1, r);
      gotoCount(15);
      echo_in = 1'b1;
      waitValid("t5_valid");
      echo_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkOutput("t5_hold_valid", 32'(tof_valid_out), 1);
         checkOutput("t5_hold_busy", 32'(busy_out), 1);
         checkOutput("t5_hold_tof", 32'(tof_out), 32'(r.tof));
         checkOutput("t5_hold_timeout", 32'(timeout_out), 32'(r.to));
         start_in = (i == 2);
         @(negedge clk_in);
      end
      start_in = 1'b0;
      tof_ready_in = 1'b1;
      @(negedge clk_in);
      checkOutput("t5_idle_busy", 32'(busy_out), 0);
      checkOutput("t5_idle_valid", 32'(tof_valid_out), 0);
      @(negedge clk_in);
      checkOutput("t5_no_queued_start", 32'(busy_out), 0);

      // Test 6: asynchronous reset mid-listen, then a fresh ping
      $display("[TB] test 6: async reset");
      applyStimulus(1'b0, r);
      gotoCount(20);
      #2;
      rst_in = 1'b0;
      #1;
      checkOutput("t6_rst_busy", 32'(busy_out), 0);
      checkOutput("t6_rst_tx_en", 32'(tx_en_out), 0);
      checkOutput("t6_rst_valid", 32'(tof_valid_out), 0);
      checkOutput("t6_rst_timeout", 32'(timeout_out), 0);
      @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      expectEcho(20, r);
      applyStimulus(1'b1, r);
      checkOutput("t6_tx_en_c0", 32'(tx_en_out), 1);
      gotoCount(20);
      echo_in = 1'b1;
      waitValid("t6_valid");
      @(negedge clk_in);
      echo_in = 1'b0;
      repeat (3) @(negedge clk_in);

      checkOutput("sb_drained", 32'(sbQ.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/echo_timer.md
Name: echo_timer

Overview:
Per-ping sonar time-of-flight stage. On a start request it drives the transducer burst enable and blanks out ringdown. It then times the first rising edge of the echo detector input against a timeout, and hands the measured cycle count downstream over a valid/ready handshake.
It sits between the ping scheduler (which issues start_in) and the range/display logic (which consumes tof_out).

Parameters:
BURST_CYCLES, 4000, cycles tx_en_out stays high per ping (40 us at 100 MHz)
BLANK_CYCLES, 20000, cycles after burst during which echo edges are ignored
TIMEOUT_CYCLES, 2000000, total cycles from burst start after which a ping is declared lost (20 ms); must be greater than BURST_CYCLES+BLANK_CYCLES
TOF_W, $clog2(TIMEOUT_CYCLES), width of tof_out

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset; asynchronous, active-low
start_in  input  1  single-cycle ping request; honoured only in IDLE
echo_in  input  1  echo comparator level (asynchronous when ECHO_TIMER_SYNC_EN is defined)
tx_en_out  output  1  transducer burst enable
busy_out  output  1  high in every state except IDLE
tof_out  output  TOF_W  cycles from burst start to detected echo edge; 0 on timeout
timeout_out  output  1  qualifies tof_out: no echo before TIMEOUT_CYCLES
tof_valid_out  output  1  result valid
tof_ready_in  input  1  downstream accept

Behaviour:
- Reset (rst_in low, any time, including mid-ping): state IDLE; all outputs 0; cycle counter 0; synchronizer flops 0. No clock is required for reset to take effect.
- States: IDLE, BURST, BLANK, LISTEN, REPORT.
- IDLE -> BURST: on the first clock edge with start_in=1. Cycle counter loads 0 on that edge.
- Counter: increments by 1 every cycle in BURST, BLANK and LISTEN. Saturating logic is not needed because the timeout bounds it.
- BURST: tx_en_out=1 exactly BURST_CYCLES cycles (counter 0..BURST_CYCLES-1), then go to BLANK.
- BLANK: leave when counter == BURST_CYCLES+BLANK_CYCLES-1, then go to LISTEN.
- LISTEN, echo found: on a rising edge of the (possibly synchronized) echo signal, latch the counter value of that cycle into tof_out, clear timeout_out, and go to REPORT.
- LISTEN, timeout: if counter == TIMEOUT_CYCLES-1 and there is no edge in that cycle, set tof_out=0 and timeout_out=1, and go to REPORT.
- Edge and timeout in the same cycle: the edge wins.
- Edge definition: rising edge = current sample 1, previous sample 0. The previous-sample register updates in every state, so an echo that is already high on entry to LISTEN is not an edge. Edges in BURST or BLANK are discarded.
- REPORT: tof_valid_out=1. tof_out and timeout_out are held stable until the handshake. The handshake completes in the cycle tof_valid_out & tof_ready_in; next state is IDLE with tof_valid_out=0. tof_ready_in may be high before valid.
- start_in is ignored outside IDLE, with no queuing. A start arriving in the handshake cycle is dropped.
- The next ping can start one cycle after return to IDLE.
- tx_en_out, busy_out and tof_valid_out are registered state decodes with no combinational input-to-output paths.

Optional Feature:
ECHO_TIMER_SYNC_EN.
- Defined: echo_in passes through a 2-flop synchronizer before edge detection. Reported tof_out includes the 2-cycle synchronizer delay; no compensation is applied.
- Undefined: echo_in is treated as synchronous to clk_in and goes directly to edge detection. tof_out is 2 cycles smaller for the same pin timing.

Decomposition:
- Package echo_timer_pkg: state enum typedef (IDLE, BURST, BLANK, LISTEN, REPORT) and a localparam helper for counter width.
- Sub-module echo_edge_detect: synchronizer (macro-gated) plus previous-sample register. Output is a one-cycle rise pulse.
- FSM, counter and output registers stay in echo_timer.

Test Plan:
All with BURST_CYCLES=4, BLANK_CYCLES=6, TIMEOUT_CYCLES=50, sync disabled.
1. start pulse, echo rises when counter=20, ready=1 -> tx_en high 4 cycles; valid with tof_out=20, timeout_out=0; returns to IDLE next cycle.
2. echo pulses at counter=3 and 7 (BURST/BLANK) only -> no detection; timeout at counter=49; valid with tof_out=0, timeout_out=1.
3. echo rising at counter=49 -> edge wins: tof_out=49, timeout_out=0.
4. echo held high from start through LISTEN -> no edge; timeout result.
5. ready low 5 cycles after valid, start pulsed during wait -> outputs stable, start ignored, busy_out=1; IDLE after ready.
6. rst_in low asynchronously mid-LISTEN -> outputs 0 before the next clock edge; next start times correctly from 0.
7. Repeat test 1 with ECHO_TIMER_SYNC_EN defined -> tof_out=22.
